qsys_system_nios2_oci_dct_packer: RTL and testbench
===================================================

# qsys_system_nios2_oci_dct_packer

Producer side of the OCI direct-compressed-trace (DCT) frame path. Accepts one 2-bit trace code per cycle from the Nios II OCI trace logic and packs up to 15 codes into a 30-bit `dct_buffer` frame with a 4-bit `dct_count`. Each frame is handed to the trace FIFO / simulation monitor through a valid/ready holding register. Codes that cannot be stored are dropped rather than stalling the CPU.

## Interface
Parameters:
- `DCT_DEPTH`, 15: codes per frame.
- `CODE_W`, 2: bits per code; frame width = `DCT_DEPTH*CODE_W` = 30.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `code_valid` in 1: `code` is presented this cycle; no backpressure.
- `code` in 2: trace code.
- `flush` in 1: close the current partial frame (trace stop, exception, debug entry).
- `frame_ready` in 1: consumer accepts the frame.
- `frame_valid` out 1: frame held in the output register.
- `dct_buffer` out 30: packed codes; code k at bits [2k+1:2k].
- `dct_count` out 4: number of valid codes, 1..15 whenever `frame_valid`=1.
- `drop_count` out 8: saturating count of dropped codes (see Configuration).

## Operation
- Internal state: accumulator `acc[29:0]`, `acc_cnt[3:0]`, FSM {FILL, HOLD}.
- `slot_free` = `!frame_valid || frame_ready`.

FILL:
- On `code_valid`, write `code` to `acc[2*acc_cnt+1 : 2*acc_cnt]` and increment `acc_cnt`.
- Go to HOLD if the new `acc_cnt`==15, or if `flush`=1 and the new `acc_cnt`>0. If both `code_valid` and `flush` are set, the code is included in the flushed frame.
- `flush` with `acc_cnt`==0 and no code: no effect; an empty frame is never produced.

HOLD (accumulator frozen):
- If `slot_free`:
  - Load the output register with `acc` and `acc_cnt`; set `frame_valid`=1.
  - Clear `acc` to 0 and `acc_cnt` to 0.
  - If `code_valid`, place the code at position 0 (`acc_cnt`=1).
  - Next state is HOLD if `flush` && `code_valid`; otherwise FILL.
- If not `slot_free`: any incoming code is dropped and `drop_count` increments. `flush` is ignored because a flush is already pending.

Output register:
- `frame_valid` is cleared on `frame_valid && frame_ready` unless it is reloaded in the same cycle.
- `dct_buffer` and `dct_count` hold stable while `frame_valid`=1 and `frame_ready`=0.
- Unused high bits of `dct_buffer` are always 0.

Codes are never reordered. Frames are emitted in arrival order.

## Timing
- Reset values:
  - `frame_valid`=0, `dct_buffer`=0, `dct_count`=0, `drop_count`=0.
  - Accumulator cleared; FSM in FILL.
- Reset asserted mid-frame discards the partial frame and the pending output.
- Code in cycle t that completes 15 codes: HOLD at t+1. With `slot_free` at t+1, `frame_valid`=1 at t+2.
- Flush in cycle t: `frame_valid` at t+2 at the earliest.
- Back-to-back frames are supported with `frame_ready` held high. One frame every 15 codes, zero drops at one code per cycle.
- Simultaneous output handoff and reload: the new frame replaces the old one in the same edge with no bubble.

## Configuration
- `NIOS2_OCI_DCT_DROP_CNT_EN` defined:
  - 8-bit `drop_count` register increments once per dropped code.
  - Saturates at 255.
  - Cleared only by reset.
- Not defined:
  - `drop_count` is tied to 8'd0 and no register is built.
  - Dropping behaviour is otherwise identical.

## Structure
- Package `nios2_oci_dct_pkg` holds:
  - `DCT_DEPTH`, `DCT_CODE_W`, `DCT_BUF_W`.
  - FSM state enum {FILL, HOLD}.
  - Code encodings: 2'b01 not-taken, 2'b10 taken, 2'b11 exception, 2'b00 reserved. These are passed through unchanged by the packer.
- Sub-module `qsys_system_nios2_oci_dct_frame_reg` contains the output holding register and its valid/ready logic. The top level contains the accumulator and the FSM.

## Test plan
- 15 codes 2'b01 on consecutive cycles, `frame_ready`=1:
  - Expect `frame_valid` 2 cycles after the last code.
  - `dct_buffer`=30'h15555555, `dct_count`=15.
- 3 codes (01, 10, 11), then `flush`:
  - Expect `dct_buffer`=30'h39, `dct_count`=3.
  - A flush with an empty accumulator produces no frame.
- `frame_ready`=0 with 15 codes, then 15 more codes, then 5 more codes:
  - Expect the first frame held stable.
  - 5 codes dropped; `drop_count`=5, or 0 without the macro.
  - After `frame_ready`, expect the second frame with 15 codes.
- 30 codes at one per cycle, `frame_ready`=1:
  - Expect two frames, no drops.
  - The 16th code is at bit position 0 of the second frame.
- `reset_n` low mid-frame (7 codes accumulated, frame pending):
  - All outputs go to 0 immediately.
  - The next 15 codes form a clean frame.
- 300 drops with the macro defined: `drop_count` saturates at 255.

Source files
------------

// File: rtl/nios2_oci_dct_pkg.sv
// Shared types and constants for the OCI direct-compressed-trace packer.
// Holds frame geometry, FSM state enum and trace code encodings.
package nios2_oci_dct_pkg;

    localparam int DCT_DEPTH  = 15;
    localparam int DCT_CODE_W = 2;
    localparam int DCT_BUF_W  = DCT_DEPTH * DCT_CODE_W;

    typedef enum logic {
        DCT_FILL = 1'b0,
        DCT_HOLD = 1'b1
    } dct_state_e;

    // Trace code encodings; the packer passes them through unchanged.
    localparam logic [1:0] DCT_CODE_RSVD = 2'b00;
    localparam logic [1:0] DCT_CODE_NT   = 2'b01;
    localparam logic [1:0] DCT_CODE_TK   = 2'b10;
    localparam logic [1:0] DCT_CODE_EXC  = 2'b11;

endpackage

// File: rtl/qsys_system_nios2_oci_dct_frame_reg.sv
// DCT frame output holding register with valid/ready handoff.
// Ports: clk, reset_n, load/load_buf/load_cnt in, frame_ready in,
//        frame_valid/dct_buffer/dct_count out.
module qsys_system_nios2_oci_dct_frame_reg
    import nios2_oci_dct_pkg::*;
#(
    parameter int BUF_W = DCT_BUF_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [BUF_W-1:0] load_buf,
    input  logic [3:0]       load_cnt,
    input  logic             frame_ready,
    output logic             frame_valid,
    output logic [BUF_W-1:0] dct_buffer,
    output logic [3:0]       dct_count
);

    // A reload in the same edge as a handoff wins, so back-to-back
    // frames leave no bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_valid <= 1'b0;
            dct_buffer  <= '0;
            dct_count   <= '0;
        end else if (load) begin
            frame_valid <= 1'b1;
            dct_buffer  <= load_buf;
            dct_count   <= load_cnt;
        end else if (frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/qsys_system_nios2_oci_dct_packer.sv
// Packs 2-bit OCI trace codes into 30-bit DCT frames; drops when full.
// Ports: clk, reset_n, code_valid/code/flush in, frame_ready in,
//        frame_valid/dct_buffer/dct_count/drop_count out.
// Optional drop counter: NIOS2_OCI_DCT_DROP_CNT_EN.
module qsys_system_nios2_oci_dct_packer #(
    parameter int DCT_DEPTH = nios2_oci_dct_pkg::DCT_DEPTH,
    parameter int CODE_W    = nios2_oci_dct_pkg::DCT_CODE_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          code_valid,
    input  logic [CODE_W-1:0]             code,
    input  logic                          flush,
    input  logic                          frame_ready,
    output logic                          frame_valid,
    output logic [DCT_DEPTH*CODE_W-1:0]   dct_buffer,
    output logic [3:0]                    dct_count,
    output logic [7:0]                    drop_count
);

    import nios2_oci_dct_pkg::*;

    localparam int BUF_W = DCT_DEPTH * CODE_W;
    localparam int SH_W  = $clog2(BUF_W);
    localparam logic [3:0] FULL = 4'(DCT_DEPTH);

    dct_state_e       state_q, state_d;
    logic [BUF_W-1:0] acc_q, acc_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             load;
    logic             slot_free;
    logic [SH_W-1:0]  sh;
    logic [BUF_W-1:0] code_ext;

    assign slot_free = !frame_valid || frame_ready;
    assign code_ext  = BUF_W'(code);
    assign sh        = SH_W'(cnt_q) * SH_W'(CODE_W);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DCT_FILL;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            DCT_FILL: begin
                if (code_valid) begin
                    acc_d = acc_q | (code_ext << sh);
                    cnt_d = cnt_q + 4'd1;
                end
                // A code arriving with flush rides in the flushed frame.
                if (cnt_d == FULL || (flush && cnt_d != 4'd0))
                    state_d = DCT_HOLD;
            end
            DCT_HOLD: begin
                // Without a free slot the accumulator stays frozen.
                if (slot_free) begin
                    load  = 1'b1;
                    acc_d = code_valid ? code_ext : '0;
                    cnt_d = {3'b000, code_valid};
                    if (flush && code_valid)
                        state_d = DCT_HOLD;
                    else
                        state_d = DCT_FILL;
                end
            end
            default: state_d = DCT_FILL;
        endcase
    end

    qsys_system_nios2_oci_dct_frame_reg #(
        .BUF_W(BUF_W)
    ) u_frame_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .load_buf   (acc_q),
        .load_cnt   (cnt_q),
        .frame_ready(frame_ready),
        .frame_valid(frame_valid),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count)
    );

`ifdef NIOS2_OCI_DCT_DROP_CNT_EN
    logic       drop;
    logic [7:0] drop_q;

    assign drop = (state_q == DCT_HOLD) && !slot_free && code_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            drop_q <= 8'd0;
        else if (drop && drop_q != 8'hFF)
            drop_q <= drop_q + 8'd1;
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_qsys_system_nios2_oci_dct_packer.sv
// Directed self-checking bench for the DCT frame packer.
// Covers latency, flush, backpressure drops, back-to-back and reset.
module tb_qsys_system_nios2_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        code_valid;
    logic [1:0]  code;
    logic        flush;
    logic        frame_ready;
    logic        frame_valid;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [7:0]  drop_count;

    int n_vec = 0;
    int n_bad = 0;

    logic [29:0] q_buf[$];
    logic [3:0]  q_cnt[$];

`ifdef NIOS2_OCI_DCT_DROP_CNT_EN
    localparam int EXP_DROP = 5;
`else
    localparam int EXP_DROP = 0;
`endif

    always #5 clk = ~clk;

    qsys_system_nios2_oci_dct_packer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .code_valid (code_valid),
        .code       (code),
        .flush      (flush),
        .frame_ready(frame_ready),
        .frame_valid(frame_valid),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .drop_count (drop_count)
    );

    // Record every frame handed off at the coming edge.
    always @(negedge clk) begin
        if (reset_n && frame_valid && frame_ready) begin
            q_buf.push_back(dct_buffer);
            q_cnt.push_back(dct_count);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] c,
                         input logic f);
        code_valid = v;
        code       = c;
        flush      = f;
        step();
    endtask

    initial begin
        reset_n     = 1'b0;
        code_valid  = 1'b0;
        code        = 2'b00;
        flush       = 1'b0;
        frame_ready = 1'b0;
        #1;
        chk("rst_valid", frame_valid, 0);
        chk("rst_buf", dct_buffer, 0);
        chk("rst_cnt", dct_count, 0);
        chk("rst_drop", drop_count, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Full frame of not-taken codes, 2-cycle latency.
        frame_ready = 1'b1;
        for (int i = 0; i < 15; i++) drive(1'b1, 2'b01, 1'b0);
        chk("t1_lat", frame_valid, 0);
        drive(1'b0, 2'b00, 1'b0);
        chk("t1_valid", frame_valid, 1);
        chk("t1_buf", dct_buffer, 30'h15555555);
        chk("t1_cnt", dct_count, 15);
        drive(1'b0, 2'b00, 1'b0);
        chk("t1_clr", frame_valid, 0);

        // Partial frame closed by flush.
        drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b10, 1'b0);
        drive(1'b1, 2'b11, 1'b0);
        drive(1'b0, 2'b00, 1'b1);
        chk("t2_lat", frame_valid, 0);
        drive(1'b0, 2'b00, 1'b0);
        chk("t2_valid", frame_valid, 1);
        chk("t2_buf", dct_buffer, 30'h39);
        chk("t2_cnt", dct_count, 3);
        drive(1'b0, 2'b00, 1'b0);
        chk("t2_clr", frame_valid, 0);
        drive(1'b0, 2'b00, 1'b1);
        drive(1'b0, 2'b00, 1'b0);
        drive(1'b0, 2'b00, 1'b0);
        chk("t2_empty", frame_valid, 0);

        // Backpressure: hold first frame, fill second, drop five.
        frame_ready = 1'b0;
        for (int i = 0; i < 15; i++) drive(1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 2'b11, 1'b0);
        chk("t3_hold_v", frame_valid, 1);
        chk("t3_hold_b", dct_buffer, 30'h2AAAAAAA);
        chk("t3_hold_c", dct_count, 15);
        drive(1'b0, 2'b00, 1'b0);
        chk("t3_drop", drop_count, EXP_DROP);
        frame_ready = 1'b1;
        drive(1'b0, 2'b00, 1'b0);
        chk("t3_b_valid", frame_valid, 1);
        chk("t3_b_buf", dct_buffer, 30'h3FFFFFFF);
        chk("t3_b_cnt", dct_count, 15);
        drive(1'b0, 2'b00, 1'b0);
        chk("t3_clr", frame_valid, 0);

        // 30 codes back to back, no drops.
        q_buf.delete();
        q_cnt.delete();
        for (int i = 0; i < 15; i++) drive(1'b1, 2'b10, 1'b0);
        drive(1'b1, 2'b11, 1'b0);
        for (int i = 0; i < 14; i++) drive(1'b1, 2'b01, 1'b0);
        repeat (4) drive(1'b0, 2'b00, 1'b0);
        chk("t4_nframes", q_buf.size(), 2);
        if (q_buf.size() >= 2) begin
            chk("t4_f0_buf", q_buf[0], 30'h2AAAAAAA);
            chk("t4_f0_cnt", q_cnt[0], 15);
            chk("t4_f1_buf", q_buf[1], 30'h15555557);
            chk("t4_f1_cnt", q_cnt[1], 15);
        end
        chk("t4_drop", drop_count, EXP_DROP);

        // Reset mid-frame with a frame pending.
        frame_ready = 1'b0;
        for (int i = 0; i < 15; i++) drive(1'b1, 2'b01, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b1, 2'b10, 1'b0);
        code_valid = 1'b0;
        chk("t5_pend", frame_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_v", frame_valid, 0);
        chk("t5_rst_b", dct_buffer, 0);
        chk("t5_rst_c", dct_count, 0);
        chk("t5_rst_d", drop_count, 0);
        #2 reset_n = 1'b1;
        step();
        q_buf.delete();
        q_cnt.delete();
        frame_ready = 1'b1;
        for (int i = 0; i < 15; i++) drive(1'b1, 2'b01, 1'b0);
        repeat (3) drive(1'b0, 2'b00, 1'b0);
        chk("t5_nframes", q_buf.size(), 1);
        if (q_buf.size() >= 1) begin
            chk("t5_buf", q_buf[0], 30'h15555555);
            chk("t5_cnt", q_cnt[0], 15);
        end

`ifdef NIOS2_OCI_DCT_DROP_CNT_EN
        // Saturation of the drop counter.
        frame_ready = 1'b0;
        for (int i = 0; i < 30; i++) drive(1'b1, 2'b11, 1'b0);
        for (int i = 0; i < 300; i++) drive(1'b1, 2'b01, 1'b0);
        chk("t6_sat", drop_count, 255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
